// File: rtl/sensor_snapshot_bank.sv
// Circular history of sensor frames with edge-triggered save, load-by-age and
// timed oldest-to-newest playback.
module sensor_snapshot_bank #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PLAY_DIV   = 4,
  parameter bit          OVERWRITE  = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      save_req,
  input  logic                      load_req,
  input  logic [$clog2(DEPTH)-1:0]  load_age,
  input  logic                      play_start,
  input  logic                      clear,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      out_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      busy,
  output logic                      load_err,
  output logic                      save_drop,
  output logic                      play_done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned DivW = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;

  localparam logic [CW-1:0]   CountFull = CW'(DEPTH);
  localparam logic [DivW-1:0] DivReload = DivW'(PLAY_DIV - 1);

  typedef enum logic {StIdle, StPlay} state_e;

  state_e                state_q;
  logic                  save_q, load_q, play_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, remaining_q;
  logic [DivW-1:0]       div_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          save_ev, load_ev, play_ev;
  logic          is_idle, is_full;
  logic          save_ok, save_rej, load_ok, load_rej;
  logic [AW-1:0] load_addr, rd_addr;

  always_comb begin
    save_ev   = save_req & ~save_q;
    load_ev   = load_req & ~load_q;
    play_ev   = play_start & ~play_q;
    is_idle   = (state_q == StIdle);
    is_full   = (count_q == CountFull);
    // clear wins over a same-cycle save and leaves nothing for a load to hit
    save_ok   = save_ev & is_idle & ~clear & (~is_full | OVERWRITE);
    save_rej  = save_ev & ~clear & (~is_idle | (is_full & ~OVERWRITE));
    load_ok   = load_ev & is_idle & ~clear & ({1'b0, load_age} < count_q);
    load_rej  = load_ev & ~load_ok;
    load_addr = wr_ptr_q - AW'(1) - load_age;
    rd_addr   = is_idle ? load_addr : rd_ptr_q;
  end

  // Write and read share the edge, so a same-cycle load sees pre-save contents.
  always_ff @(posedge clock) begin
    if (save_ok && !reset) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      save_q      <= 1'b0;
      load_q      <= 1'b0;
      play_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      div_q       <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      load_err    <= 1'b0;
      save_drop   <= 1'b0;
      play_done   <= 1'b0;
    end else begin
      save_q    <= save_req;
      load_q    <= load_req;
      play_q    <= play_start;
      out_valid <= 1'b0;
      play_done <= 1'b0;
      load_err  <= load_rej;
      save_drop <= save_rej;

      if (load_ok) begin
        data_out  <= mem[rd_addr];
        out_valid <= 1'b1;
      end

      if (clear) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        state_q  <= StIdle;
      end else if (save_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (!is_full) count_q <= count_q + CW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (play_ev && !clear) begin
            if (count_q == '0) begin
              play_done <= 1'b1;
            end else begin
              state_q     <= StPlay;
              rd_ptr_q    <= wr_ptr_q - AW'(count_q);
              remaining_q <= count_q;
              div_q       <= '0;
            end
          end
        end
        StPlay: begin
          if (!clear) begin
            if (div_q == '0) begin
              data_out    <= mem[rd_addr];
              out_valid   <= 1'b1;
              rd_ptr_q    <= rd_ptr_q + AW'(1);
              remaining_q <= remaining_q - CW'(1);
              div_q       <= DivReload;
              if (remaining_q == CW'(1)) begin
                play_done <= 1'b1;
                state_q   <= StIdle;
              end
            end else begin
              div_q <= div_q - DivW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign count = count_q;
  assign full  = is_full;
  assign busy  = (state_q == StPlay);

endmodule

// File: tb/tb_sensor_snapshot_bank.sv
// Directed bench: vector table for save/load on an overwriting bank, plus
// hand sequences for playback, clear, reset and a non-overwriting bank.
module tb_sensor_snapshot_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bank A: DEPTH 8, PLAY_DIV 4, overwrite when full.
  logic        a_rst, a_save, a_load, a_play, a_clear;
  logic [23:0] a_din, a_dout;
  logic [2:0]  a_age;
  logic [3:0]  a_count;
  logic        a_valid, a_full, a_busy, a_err, a_drop, a_done;

  // Bank B: DEPTH 16, PLAY_DIV 4, drop when full.
  logic        b_rst, b_save, b_load, b_play, b_clear;
  logic [23:0] b_din, b_dout;
  logic [3:0]  b_age;
  logic [4:0]  b_count;
  logic        b_valid, b_full, b_busy, b_err, b_drop, b_done;

  sensor_snapshot_bank #(
    .DATA_WIDTH(24), .DEPTH(8), .PLAY_DIV(4), .OVERWRITE(1'b1)
  ) u_a (
    .clock(clk), .reset(a_rst), .data_in(a_din), .save_req(a_save), .load_req(a_load),
    .load_age(a_age), .play_start(a_play), .clear(a_clear), .data_out(a_dout),
    .out_valid(a_valid), .count(a_count), .full(a_full), .busy(a_busy),
    .load_err(a_err), .save_drop(a_drop), .play_done(a_done)
  );

  sensor_snapshot_bank #(
    .DATA_WIDTH(24), .DEPTH(16), .PLAY_DIV(4), .OVERWRITE(1'b0)
  ) u_b (
    .clock(clk), .reset(b_rst), .data_in(b_din), .save_req(b_save), .load_req(b_load),
    .load_age(b_age), .play_start(b_play), .clear(b_clear), .data_out(b_dout),
    .out_valid(b_valid), .count(b_count), .full(b_full), .busy(b_busy),
    .load_err(b_err), .save_drop(b_drop), .play_done(b_done)
  );

  typedef enum logic [1:0] {OpSave, OpLoad, OpClear} op_e;

  typedef struct {
    op_e         op;
    logic [23:0] din;
    logic [2:0]  age;
    logic [23:0] exp_data;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_drop;
    logic [3:0]  exp_count;
    logic        exp_full;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_e op, input logic [23:0] din, input logic [2:0] age,
                              input logic [23:0] ed, input logic ev, input logic ee,
                              input logic edr, input logic [3:0] ec, input logic ef);
    vec_t v;
    v.op = op; v.din = din; v.age = age; v.exp_data = ed; v.exp_valid = ev;
    v.exp_err = ee; v.exp_drop = edr; v.exp_count = ec; v.exp_full = ef;
    return v;
  endfunction

  task automatic a_op(input op_e op, input logic [23:0] d, input logic [2:0] age);
    a_din   = d;
    a_age   = age;
    a_save  = (op == OpSave);
    a_load  = (op == OpLoad);
    a_clear = (op == OpClear);
    tick();
  endtask

  task automatic a_idle();
    a_save = 1'b0; a_load = 1'b0; a_clear = 1'b0; a_play = 1'b0;
    tick();
  endtask

  task automatic b_op(input op_e op, input logic [23:0] d, input logic [3:0] age);
    b_din   = d;
    b_age   = age;
    b_save  = (op == OpSave);
    b_load  = (op == OpLoad);
    b_clear = (op == OpClear);
    tick();
  endtask

  task automatic b_idle();
    b_save = 1'b0; b_load = 1'b0; b_clear = 1'b0; b_play = 1'b0;
    tick();
  endtask

  initial begin
    a_rst = 1'b1; a_save = 1'b0; a_load = 1'b0; a_play = 1'b0; a_clear = 1'b0;
    a_din = '0; a_age = '0;
    b_rst = 1'b1; b_save = 1'b0; b_load = 1'b0; b_play = 1'b0; b_clear = 1'b0;
    b_din = '0; b_age = '0;

    // Stimulus table for bank A: each entry is one single-cycle request.
    tbl.push_back(mk(OpSave, 24'hA1, 3'd0, 24'h0,  1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
    tbl.push_back(mk(OpSave, 24'hB2, 3'd0, 24'h0,  1'b0, 1'b0, 1'b0, 4'd2, 1'b0));
    tbl.push_back(mk(OpSave, 24'hC3, 3'd0, 24'h0,  1'b0, 1'b0, 1'b0, 4'd3, 1'b0));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd0, 24'hC3, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd2, 24'hA1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd3, 24'hA1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0));
    tbl.push_back(mk(OpClear, 24'h0, 3'd0, 24'hA1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd0, 24'hA1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    for (int i = 1; i <= 10; i++) begin
      tbl.push_back(mk(OpSave, 24'(i), 3'd0, 24'hA1, 1'b0, 1'b0, 1'b0,
                       (i >= 8) ? 4'd8 : 4'(i), i >= 8));
    end
    tbl.push_back(mk(OpLoad, 24'h0,  3'd7, 24'd3,  1'b1, 1'b0, 1'b0, 4'd8, 1'b1));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd0, 24'd10, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1));
    tbl.push_back(mk(OpSave, 24'h55, 3'd0, 24'd10, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd0, 24'h55, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1));
    tbl.push_back(mk(OpLoad, 24'h0,  3'd7, 24'd4,  1'b1, 1'b0, 1'b0, 4'd8, 1'b1));

    tick();
    tick();
    chk("reset outputs A",
        {a_dout, a_valid, a_count, a_full, a_busy, a_err, a_drop, a_done}, '0);
    chk("reset outputs B",
        {b_dout, b_valid, b_count, b_full, b_busy, b_err, b_drop, b_done}, '0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      a_op(tbl[i].op, tbl[i].din, tbl[i].age);
      chk($sformatf("v%0d valid", i), a_valid, tbl[i].exp_valid);
      chk($sformatf("v%0d data", i), a_dout, tbl[i].exp_data);
      chk($sformatf("v%0d load_err", i), a_err, tbl[i].exp_err);
      chk($sformatf("v%0d save_drop", i), a_drop, tbl[i].exp_drop);
      chk($sformatf("v%0d count", i), a_count, tbl[i].exp_count);
      chk($sformatf("v%0d full", i), a_full, tbl[i].exp_full);
      a_idle();
      chk($sformatf("v%0d pulses low", i), {a_valid, a_err, a_drop}, 3'b000);
    end

    // Playback of three frames at PLAY_DIV 4, with a save attempted mid-play.
    a_op(OpClear, 24'h0, 3'd0);
    a_idle();
    a_op(OpSave, 24'h11, 3'd0); a_idle();
    a_op(OpSave, 24'h22, 3'd0); a_idle();
    a_op(OpSave, 24'h33, 3'd0); a_idle();
    a_play = 1'b1;
    tick();
    a_play = 1'b0;
    chk("play entry busy", {a_busy, a_valid, a_done}, 3'b100);
    for (int i = 1; i <= 10; i++) begin
      a_save = (i == 3);
      a_din  = 24'hEE;
      tick();
      chk($sformatf("play c%0d valid", i), a_valid, (i == 1) || (i == 5) || (i == 9));
      chk($sformatf("play c%0d busy", i), a_busy, i < 9);
      chk($sformatf("play c%0d done", i), a_done, i == 9);
      chk($sformatf("play c%0d drop", i), a_drop, i == 3);
      if (i == 1) chk("play frame0", a_dout, 24'h11);
      if (i == 5) chk("play frame1", a_dout, 24'h22);
      if (i == 9) chk("play frame2", a_dout, 24'h33);
    end
    a_save = 1'b0;
    chk("play count kept", a_count, 4'd3);

    // Held save level produces one save; then save+load in the same cycle.
    a_op(OpClear, 24'h0, 3'd0);
    a_idle();
    a_din  = 24'h77;
    a_save = 1'b1;
    repeat (20) tick();
    a_idle();
    chk("held save count", a_count, 4'd1);
    a_din  = 24'h88;
    a_age  = 3'd0;
    a_save = 1'b1;
    a_load = 1'b1;
    tick();
    chk("save+load valid", a_valid, 1'b1);
    chk("save+load old data", a_dout, 24'h77);
    chk("save+load count", a_count, 4'd2);
    a_idle();
    a_op(OpLoad, 24'h0, 3'd0);
    chk("post save+load newest", a_dout, 24'h88);
    a_idle();

    // Clear while playing aborts without play_done.
    a_play = 1'b1;
    tick();
    a_play = 1'b0;
    chk("clear-play busy", a_busy, 1'b1);
    tick();
    chk("clear-play frame0", {a_valid, a_dout}, {1'b1, 24'h77});
    tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clear-play aborted", {a_busy, a_done, a_valid, a_count}, '0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        seen = seen | a_done | a_valid | a_busy;
      end
      chk("clear-play quiet", seen, 1'b0);
    end
    a_play = 1'b1;
    tick();
    a_play = 1'b0;
    chk("empty play done", {a_done, a_busy, a_valid}, 3'b100);
    tick();
    chk("empty play done pulse", a_done, 1'b0);

    // Reset in the middle of playback.
    a_op(OpSave, 24'h99, 3'd0); a_idle();
    a_op(OpSave, 24'hAA, 3'd0); a_idle();
    a_play = 1'b1;
    tick();
    a_play = 1'b0;
    tick();
    chk("pre-reset frame", {a_valid, a_dout}, {1'b1, 24'h99});
    tick();
    a_rst = 1'b1;
    tick();
    chk("reset mid-play outputs",
        {a_dout, a_valid, a_count, a_full, a_busy, a_err, a_drop, a_done}, '0);
    a_rst = 1'b0;
    tick();
    tick();
    chk("after reset idle", {a_busy, a_valid, a_done}, 3'b000);

    // Bank B: drop on full, out-of-range age.
    for (int i = 0; i < 16; i++) begin
      b_op(OpSave, 24'h100 + 24'(i), 4'd0);
      b_idle();
    end
    chk("B full", {b_count, b_full}, {5'd16, 1'b1});
    b_op(OpSave, 24'hFF, 4'd0);
    chk("B save_drop", b_drop, 1'b1);
    chk("B count held", b_count, 5'd16);
    b_idle();
    chk("B save_drop pulse", b_drop, 1'b0);
    b_op(OpLoad, 24'h0, 4'd0);
    chk("B newest kept", {b_valid, b_dout}, {1'b1, 24'h10F});
    b_idle();
    b_op(OpLoad, 24'h0, 4'd15);
    chk("B oldest", b_dout, 24'h100);
    b_idle();
    b_op(OpClear, 24'h0, 4'd0);
    b_idle();
    for (int i = 0; i < 4; i++) begin
      b_op(OpSave, 24'h200 + 24'(i), 4'd0);
      b_idle();
    end
    b_op(OpLoad, 24'h0, 4'd3);
    chk("B age3", {b_valid, b_dout}, {1'b1, 24'h200});
    b_idle();
    b_op(OpLoad, 24'h0, 4'd8);
    chk("B age8 err", {b_err, b_valid}, 2'b10);
    chk("B age8 data held", b_dout, 24'h200);
    chk("B count4", b_count, 5'd4);
    b_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sensor_snapshot_bank.md
Name: sensor_snapshot_bank

Overview:
Parametrised capture/replay store for sensor frames. It generalises the single-frame save/load path between the VGA controller and the processor into a DEPTH-slot circular history. The bank supports three operations: edge-triggered save, random-access load by age, and a timed playback mode that streams every stored frame from oldest to newest. It sits between the sensor input / VGA control strobes and the processor's memory-mapped sensor address.

Parameters:
DATA_WIDTH, 24, bits per sensor frame (only the low 24 bits of the sensor bus are meaningful).
DEPTH, 8, number of snapshot slots; must be a power of 2 and at least 2.
PLAY_DIV, 4, clock cycles between successive playback outputs; must be at least 1.
OVERWRITE, 1, behaviour when full: 1 = overwrite the oldest slot, 0 = drop the save and pulse save_drop.

Ports:
clock  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
data_in  in  DATA_WIDTH  live sensor frame, sampled on an accepted save.
save_req  in  1  level input; its rising edge requests a save.
load_req  in  1  level input; its rising edge requests a load.
load_age  in  clog2(DEPTH)  age of the slot to load (0 = newest).
play_start  in  1  level input; its rising edge starts playback.
clear  in  1  synchronous flush of stored contents (count returns to 0).
data_out  out  DATA_WIDTH  last loaded or played frame; held between updates.
out_valid  out  1  1-cycle pulse when data_out updates.
count  out  clog2(DEPTH)+1  number of valid slots, 0..DEPTH.
full  out  1  asserted when count == DEPTH.
busy  out  1  asserted while in PLAY.
load_err  out  1  1-cycle pulse when a load is rejected.
save_drop  out  1  1-cycle pulse when a save is rejected.
play_done  out  1  1-cycle pulse when playback ends.

Behaviour:
- Reset: all outputs 0; wr_ptr = 0; count = 0; state IDLE; edge-detect history registers = 0. Memory contents are don't-care after reset.
- Edge detect: each of save_req, load_req and play_start is registered once. An event is input high while the registered copy is low. A held level produces exactly one event.
- Save event, IDLE, count < DEPTH: mem[wr_ptr] <= data_in; wr_ptr increments mod DEPTH; count increments.
- Save event, IDLE, full:
  - OVERWRITE = 1: write proceeds and wr_ptr advances; count stays at DEPTH.
  - OVERWRITE = 0: no write; save_drop pulses.
- Save event during PLAY: dropped; save_drop pulses.
- Load event, IDLE, load_age < count: data_out <= mem[(wr_ptr - 1 - load_age) mod DEPTH]. out_valid pulses on the cycle after the event (1-cycle latency).
- Load event with load_age >= count, or during PLAY: load_err pulses; data_out unchanged.
- Save and load events in the same cycle: the load address is computed from the pre-save wr_ptr and count, so the load returns old data. The save still completes in that cycle.
- Playback FSM, IDLE -> PLAY on a play_start event:
  - If count == 0: no transition; play_done pulses next cycle; no out_valid.
  - Otherwise latch rd_ptr = (wr_ptr - count) mod DEPTH, latch remaining = count, load the divider with 0.
- PLAY state:
  - When the divider reaches 0: data_out <= mem[rd_ptr], out_valid pulses, rd_ptr increments, remaining decrements, divider reloads PLAY_DIV - 1.
  - The first frame is output on the cycle after entry.
  - When the last frame is output: play_done pulses on the same cycle and the state returns to IDLE on the next edge.
- busy: asserted for the whole of PLAY.
- play_start event during PLAY: ignored.
- clear:
  - IDLE: count and wr_ptr go to 0; overrides a same-cycle save; a same-cycle load is evaluated against the cleared state (load_err).
  - PLAY: aborts playback to IDLE without a play_done pulse, then flushes as in IDLE.
- reset mid-PLAY: immediate return to IDLE with all outputs 0.
- Pointer arithmetic: done in clog2(DEPTH) bits with natural wrap.
- count: saturates at DEPTH and never underflows.

Test Plan:
- Reset, then 3 saves of 0xA1, 0xB2, 0xC3 -> count = 3. Load age 0 -> 0xC3; load age 2 -> 0xA1; out_valid is 1 cycle each, 1 cycle after the event.
- DEPTH = 8, OVERWRITE = 1, save values 1..10 -> count = 8, full = 1. Load age 7 -> 3; load age 0 -> 10.
- OVERWRITE = 0, full, then save 0xFF -> save_drop pulses; load age 0 still returns the prior newest. Load age 8 with count = 4 -> load_err pulses and data_out is held.
- 3 stored, PLAY_DIV = 4, play_start -> out_valid at cycles +1, +5, +9 carrying oldest to newest; play_done pulses with the third frame; busy spans all cycles of PLAY. A save during PLAY produces save_drop.
- save_req held high for 20 cycles -> exactly 1 save. Simultaneous save and load (age 0) events -> the load returns the pre-save newest frame and count increments.
- clear asserted mid-playback -> busy falls, no play_done, count = 0. A subsequent play_start produces only play_done. Reset asserted mid-PLAY -> all outputs 0 on the next cycle.
